// File: rtl/demux_1to4_buf.sv
// One-to-four result distributor: each channel owns a one-entry output register with
// valid/ready, so a stalled sink only blocks input words routed to it.
module demux_1to4_buf #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          in_sel_i,
  input  logic [DATA_W-1:0]   in_data_i,
  output logic [3:0]          out_valid_o,
  input  logic [3:0]          out_ready_i,
  output logic [4*DATA_W-1:0] out_data_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    xfer_cnt_o
);

  logic [3:0]             valid_q;
  logic [3:0][DATA_W-1:0] data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   acc;

  // A full channel still accepts if its sink drains it in the same cycle.
  assign in_ready_o = ~valid_q[in_sel_i] | out_ready_i[in_sel_i];
  assign acc        = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (acc && (in_sel_i == 2'(n))) begin
          data_q[n]  <= in_data_i;
          valid_q[n] <= 1'b1;
        end else if (valid_q[n] && out_ready_i[n]) begin
          valid_q[n] <= 1'b0;
        end
      end
      if (acc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign busy_o      = |valid_q;
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed self-checking bench for demux_1to4_buf: reset, routing, stall isolation,
// pass-through streaming, counter wrap with per-channel scoreboard, reset mid-operation.
module tb_demux_1to4_buf;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  in_sel_i;
  logic [15:0] in_data_i;
  logic [3:0]  out_valid_o;
  logic [3:0]  out_ready_i;
  logic [63:0] out_data_o;
  logic        busy_o;
  logic [7:0]  xfer_cnt_o;

  int checks = 0;
  int errors = 0;

  demux_1to4_buf #(.DATA_W(16), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_sel_i(in_sel_i), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o),
    .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] ch(input int n);
    return out_data_o[n*16 +: 16];
  endfunction

  logic [15:0] sb [4][$];
  logic [7:0]  exp_cnt;
  bit          saw_zero;

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b1; in_sel_i = 2'd0; in_data_i = 16'hFFFF;
    out_ready_i = 4'b0000;

    // T1 reset with input valid
    step(); step();
    check_eq("t1_valid", out_valid_o, 4'b0000);
    check_eq("t1_data", out_data_o, 64'h0);
    check_eq("t1_cnt", xfer_cnt_o, 8'd0);
    check_eq("t1_busy", busy_o, 1'b0);
    rst_i = 1'b1; in_valid_i = 1'b0;
    step();
    check_eq("t1_idle_cnt", xfer_cnt_o, 8'd0);

    // T2 single route to ch2, then stall
    in_valid_i = 1'b1; in_sel_i = 2'd2; in_data_i = 16'hA5A5;
    #1 check_eq("t2_ready", in_ready_o, 1'b1);
    step();
    in_valid_i = 1'b0;
    check_eq("t2_valid", out_valid_o, 4'b0100);
    check_eq("t2_data", ch(2), 16'hA5A5);
    check_eq("t2_cnt", xfer_cnt_o, 8'd1);
    check_eq("t2_busy", busy_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_hold_valid", out_valid_o, 4'b0100);
      check_eq("t2_hold_data", ch(2), 16'hA5A5);
    end

    // T3 stall isolation
    in_valid_i = 1'b1; in_sel_i = 2'd2; in_data_i = 16'h1111;
    #1 check_eq("t3_blocked", in_ready_o, 1'b0);
    step();
    check_eq("t3_cnt_blocked", xfer_cnt_o, 8'd1);
    check_eq("t3_ch2_kept", ch(2), 16'hA5A5);
    in_sel_i = 2'd0; in_data_i = 16'h2222;
    #1 check_eq("t3_ready_ch0", in_ready_o, 1'b1);
    step();
    in_valid_i = 1'b0;
    check_eq("t3_valid", out_valid_o, 4'b0101);
    check_eq("t3_ch0", ch(0), 16'h2222);
    check_eq("t3_ch2", ch(2), 16'hA5A5);
    check_eq("t3_cnt", xfer_cnt_o, 8'd2);

    // T4 pass-through on ch1
    out_ready_i = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      in_valid_i = 1'b1; in_sel_i = 2'd1; in_data_i = 16'(i);
      #1 check_eq("t4_ready", in_ready_o, 1'b1);
      step();
      check_eq("t4_ch1", ch(1), 16'(i));
      check_eq("t4_valid1", out_valid_o[1], 1'b1);
    end
    in_valid_i = 1'b0;
    check_eq("t4_cnt", xfer_cnt_o, 8'd6);
    step();
    check_eq("t4_drained", out_valid_o, 4'b0101);
    check_eq("t4_ch1_held", ch(1), 16'd4);

    // T5 256 words round-robin with all sinks ready
    out_ready_i = 4'b1111;
    step();
    check_eq("t5_empty", out_valid_o, 4'b0000);
    exp_cnt = 8'd6; saw_zero = 1'b0;
    for (int i = 0; i < 257; i++) begin
      if (i < 256) begin
        in_valid_i = 1'b1; in_sel_i = 2'(i % 4); in_data_i = 16'h5000 + 16'(i);
        #1;
        if (in_ready_o) begin
          sb[i % 4].push_back(16'h5000 + 16'(i));
          exp_cnt = exp_cnt + 8'd1;
        end
        check_eq("t5_ready", in_ready_o, 1'b1);
      end else begin
        in_valid_i = 1'b0;
      end
      step();
      check_eq("t5_cnt", xfer_cnt_o, exp_cnt);
      if (xfer_cnt_o == 8'd0) saw_zero = 1'b1;
      for (int n = 0; n < 4; n++) begin
        if (out_valid_o[n]) begin
          if (sb[n].size() == 0) check_eq("t5_extra_word", 1'b1, 1'b0);
          else check_eq("t5_sb_data", ch(n), sb[n].pop_front());
        end
      end
    end
    check_eq("t5_wrapped_zero", saw_zero, 1'b1);
    check_eq("t5_cnt_final", xfer_cnt_o, 8'd6);
    check_eq("t5_sb_left", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);

    // T6 fill all, stall, reset pulse
    out_ready_i = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      in_valid_i = 1'b1; in_sel_i = 2'(n); in_data_i = 16'hC000 + 16'(n);
      step();
    end
    in_valid_i = 1'b0;
    check_eq("t6_full", out_valid_o, 4'b1111);
    check_eq("t6_ch3", ch(3), 16'hC003);
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    check_eq("t6_valid", out_valid_o, 4'b0000);
    check_eq("t6_busy", busy_o, 1'b0);
    check_eq("t6_data", out_data_o, 64'h0);
    check_eq("t6_cnt", xfer_cnt_o, 8'd0);
    in_valid_i = 1'b1; in_sel_i = 2'd3; in_data_i = 16'hBEEF;
    step();
    in_valid_i = 1'b0;
    check_eq("t6_route_valid", out_valid_o, 4'b1000);
    check_eq("t6_route_data", ch(3), 16'hBEEF);
    check_eq("t6_route_cnt", xfer_cnt_o, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
